// File: rtl/keypad_event_ctrl.sv
// 3x4 keypad scanner: column drive, whole-frame debounce, and press/release events
// delivered through a small first-word-fall-through FIFO.
module keypad_event_ctrl #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    input  logic        scan_en,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [11:0] key_state,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t           r_state;
    logic [DW_W-1:0]  r_dwell;
    logic [1:0]       r_col;
    logic [2:0]       r_key_col;
    logic [11:0]      r_raw;
    logic [11:0]      r_prev;
    logic [11:0]      r_key_state;
    logic [11:0]      r_diff;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic [11:0]      w_raw_next;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_commit;
    logic             w_dwell_end;
    logic [3:0]       w_lsb;
    logic [11:0]      w_diff_next;
    logic             w_push;
    logic [4:0]       w_push_data;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;

    function automatic logic [2:0] f_col_drive(input logic [1:0] col);
        case (col)
            2'd0:    f_col_drive = 3'b110;
            2'd1:    f_col_drive = 3'b101;
            default: f_col_drive = 3'b011;
        endcase
    endfunction

    function automatic logic [3:0] f_lsb(input logic [11:0] v);
        f_lsb = 4'd0;
        for (int k = 11; k >= 0; k--) begin
            if (v[k]) f_lsb = 4'(k);
        end
    endfunction

    // The column being sampled this cycle is merged in so frame-end logic sees the whole map.
    always_comb begin
        w_raw_next = r_raw;
        case (r_col)
            2'd0:    w_raw_next[3:0]  = ~key_row;
            2'd1:    w_raw_next[7:4]  = ~key_row;
            default: w_raw_next[11:8] = ~key_row;
        endcase
    end

    assign w_dwell_end = (r_dwell == DW_W'(SCAN_DIV - 1));
    assign w_same      = (w_raw_next == r_prev);
    assign w_cnt_next  = !w_same                       ? CNT_W'(1) :
                         (r_cnt >= CNT_W'(DEB_CNT))     ? CNT_W'(DEB_CNT) :
                                                          r_cnt + 1'b1;
    assign w_commit    = (w_cnt_next == CNT_W'(DEB_CNT)) && (w_raw_next != r_key_state);

    assign w_lsb       = f_lsb(r_diff);
    assign w_diff_next = r_diff & (r_diff - 12'd1);
    assign w_push      = (r_state == S_EMIT) && (r_diff != 12'd0);
    assign w_push_data = {r_key_state[w_lsb], w_lsb};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_dwell     <= '0;
            r_col       <= 2'd0;
            r_key_col   <= 3'b111;
            r_raw       <= '0;
            r_prev      <= '0;
            r_key_state <= '0;
            r_diff      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scan_en) begin
                        r_state   <= S_SCAN;
                        r_col     <= 2'd0;
                        r_dwell   <= '0;
                        r_key_col <= 3'b110;
                    end
                end
                S_SCAN: begin
                    if (!scan_en) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_col     <= 2'd0;
                        r_dwell   <= '0;
                        r_key_col <= 3'b111;
                    end else if (!w_dwell_end) begin
                        r_dwell <= r_dwell + 1'b1;
                    end else begin
                        r_dwell <= '0;
                        r_raw   <= w_raw_next;
                        if (r_col != 2'd2) begin
                            r_col     <= r_col + 2'd1;
                            r_key_col <= f_col_drive(r_col + 2'd1);
                        end else begin
                            r_cnt  <= w_cnt_next;
                            r_prev <= w_raw_next;
                            r_col  <= 2'd0;
                            if (w_commit) begin
                                r_diff      <= w_raw_next ^ r_key_state;
                                r_key_state <= w_raw_next;
                                r_state     <= S_EMIT;
                                r_key_col   <= 3'b111;
                            end else begin
                                r_key_col <= 3'b110;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    r_diff <= w_diff_next;
                    if (w_diff_next == 12'd0) begin
                        r_col   <= 2'd0;
                        r_dwell <= '0;
                        if (scan_en) begin
                            r_state   <= S_SCAN;
                            r_key_col <= 3'b110;
                        end else begin
                            r_state   <= S_IDLE;
                            r_key_col <= 3'b111;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_key_col <= 3'b111;
                end
            endcase
        end
    end

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && evt_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
    end

    assign key_col   = r_key_col;
    assign key_state = r_key_state;
    assign overflow  = r_overflow;
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 4'd0 : r_mem[r_rd_ptr][3:0];
    assign evt_press = w_empty ? 1'b0 : r_mem[r_rd_ptr][4];

endmodule
